// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, bus source mux, and a 64-bit-result ALU
// feeding the split Z register. All registers load on the falling clock edge and
// are cleared asynchronously by `clear`.
module datapath #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              MDRread,
    input  logic              PCout,
    input  logic              MDRout,
    input  logic              MARout,
    input  logic              IRout,
    input  logic              RYout,
    input  logic              RZoutLo,
    input  logic              RZoutHi,
    input  logic              R2out,
    input  logic              R3out,
    input  logic              R4out,
    input  logic              R5out,
    input  logic              R6out,
    input  logic              R7out,
    input  logic              PCin,
    input  logic              MDRin,
    input  logic              MARin,
    input  logic              IRin,
    input  logic              RYin,
    input  logic              RZinLo,
    input  logic              RZinHi,
    input  logic              LOin,
    input  logic              HIin,
    input  logic              R2in,
    input  logic              R3in,
    input  logic              R4in,
    input  logic              R5in,
    input  logic              R6in,
    input  logic              R7in,
    input  logic              IncPC,
    output logic [DATA_W-1:0] BusMuxOut
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [DATA_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] y_q,   y_d;
    logic [DATA_W-1:0] zlo_q, zlo_d;
    logic [DATA_W-1:0] zhi_q, zhi_d;
    logic [DATA_W-1:0] lo_q,  lo_d;
    logic [DATA_W-1:0] hi_q,  hi_d;
    logic [DATA_W-1:0] gpr_q [2:7];
    logic [DATA_W-1:0] gpr_d [2:7];

    logic [7:2]          gpr_out;
    logic [7:2]          gpr_in;
    logic [DATA_W-1:0]   bus;
    logic [2*DATA_W-1:0] alu_res;

    assign gpr_out   = {R7out, R6out, R5out, R4out, R3out, R2out};
    assign gpr_in    = {R7in, R6in, R5in, R4in, R3in, R2in};
    assign BusMuxOut = bus;

    // ALU: A is the Y register, B is the bus. Only mul and div produce a nonzero
    // upper half; every other op is zero-extended. Signed div uses sign-extended
    // double-width operands so the most-negative / -1 case cannot overflow.
    function automatic logic [2*DATA_W-1:0] alu_f(
        input logic [4:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [SH_W-1:0]            n;
        logic [2*DATA_W-1:0]        dbl;
        logic signed [DATA_W-1:0]   a_s;
        logic signed [2*DATA_W-1:0] a_w;
        logic signed [2*DATA_W-1:0] b_w;
        logic [DATA_W-1:0]          lo;
        logic [DATA_W-1:0]          quo;
        logic [DATA_W-1:0]          rem;
        logic [2*DATA_W-1:0]        res;
        n   = b[SH_W-1:0];
        a_s = a;
        a_w = {{DATA_W{a[DATA_W-1]}}, a};
        b_w = {{DATA_W{b[DATA_W-1]}}, b};
        dbl = {a, a};
        lo  = '0;
        quo = '0;
        rem = '0;
        res = '0;
        case (op)
            OP_ADD:  lo = a + b;
            OP_SUB:  lo = a - b;
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_ROR: begin
                dbl = dbl >> n;
                lo  = dbl[DATA_W-1:0];
            end
            OP_ROL: begin
                dbl = dbl << n;
                lo  = dbl[2*DATA_W-1:DATA_W];
            end
            OP_SHR:  lo = a >> n;
            OP_SHRA: lo = a_s >>> n;
            OP_SHL:  lo = a << n;
            OP_NEG:  lo = -b;
            OP_NOT:  lo = ~b;
            default: lo = '0;
        endcase
        res = {{DATA_W{1'b0}}, lo};
        if (op == OP_MUL) begin
            res = a_w * b_w;
        end else if (op == OP_DIV) begin
            if (b != '0) begin
                quo = DATA_W'(a_w / b_w);
                rem = DATA_W'(a_w % b_w);
            end
            res = {rem, quo};
        end
        return res;
    endfunction

    // Bus source mux: lowest priority applied first so higher-priority sources
    // override; R2 ends up strongest. Idle bus reads as zero.
    always_comb begin
        bus = '0;
        if (RZoutLo) bus = zlo_q;
        if (RZoutHi) bus = zhi_q;
        if (RYout)   bus = y_q;
        if (IRout)   bus = ir_q;
        if (MARout)  bus = mar_q;
        if (MDRout)  bus = mdr_q;
        if (PCout)   bus = pc_q;
        for (int i = 7; i >= 2; i--) begin
            if (gpr_out[i]) bus = gpr_q[i];
        end
    end

    // ALU result; IncPC bypasses the opcode to form bus+1 (wrapping).
    always_comb begin
        alu_res = alu_f(ir_q[DATA_W-1:DATA_W-5], y_q, bus);
        if (IncPC) alu_res = {{DATA_W{1'b0}}, bus + 1'b1};
    end

    // Next-state for every register: load when enabled, otherwise hold.
    always_comb begin
        pc_d  = PCin   ? bus : pc_q;
        mdr_d = MDRin  ? (MDRread ? Mdatain : bus) : mdr_q;
        mar_d = MARin  ? bus : mar_q;
        ir_d  = IRin   ? bus : ir_q;
        y_d   = RYin   ? bus : y_q;
        lo_d  = LOin   ? bus : lo_q;
        hi_d  = HIin   ? bus : hi_q;
        zlo_d = RZinLo ? alu_res[DATA_W-1:0] : zlo_q;
        zhi_d = RZinHi ? alu_res[2*DATA_W-1:DATA_W] : zhi_q;
        for (int i = 2; i <= 7; i++) begin
            gpr_d[i] = gpr_in[i] ? bus : gpr_q[i];
        end
    end

    // Register bank: falling-edge loads, asynchronous clear wins over any load.
    always_ff @(negedge clock or posedge clear) begin
        if (clear) begin
            pc_q  <= '0;
            mdr_q <= '0;
            mar_q <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            zlo_q <= '0;
            zhi_q <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            for (int i = 2; i <= 7; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            mdr_q <= mdr_d;
            mar_q <= mar_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            zlo_q <= zlo_d;
            zhi_q <= zhi_d;
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            for (int i = 2; i <= 7; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for the single-bus datapath. Registers are observed through
// the bus; a behavioural model tracks register contents and computes ALU results.
module tb_datapath;

    localparam int C_R2  = 2;
    localparam int C_R3  = 3;
    localparam int C_R4  = 4;
    localparam int C_R5  = 5;
    localparam int C_R7  = 7;
    localparam int C_PC  = 8;
    localparam int C_MDR = 9;
    localparam int C_MAR = 10;
    localparam int C_IR  = 11;
    localparam int C_Y   = 12;
    localparam int C_ZHI = 13;
    localparam int C_ZLO = 14;

    logic        clock;
    logic        clear;
    logic [31:0] Mdatain;
    logic        MDRread;
    logic PCout, MDRout, MARout, IRout, RYout, RZoutLo, RZoutHi;
    logic R2out, R3out, R4out, R5out, R6out, R7out;
    logic PCin, MDRin, MARin, IRin, RYin, RZinLo, RZinHi, LOin, HIin;
    logic R2in, R3in, R4in, R5in, R6in, R7in;
    logic IncPC;
    logic [31:0] BusMuxOut;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m [0:16];

    datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .MDRread(MDRread),
        .PCout(PCout), .MDRout(MDRout), .MARout(MARout), .IRout(IRout),
        .RYout(RYout), .RZoutLo(RZoutLo), .RZoutHi(RZoutHi),
        .R2out(R2out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
        .R6out(R6out), .R7out(R7out),
        .PCin(PCin), .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .RYin(RYin),
        .RZinLo(RZinLo), .RZinHi(RZinHi), .LOin(LOin), .HIin(HIin),
        .R2in(R2in), .R3in(R3in), .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
        .IncPC(IncPC), .BusMuxOut(BusMuxOut)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference ALU: rotates/shifts done bit-by-bit, arithmetic in 64-bit integers.
    function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        longint sa, sb, q, rm;
        int n;
        n  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = a;
        case (op)
            3:  return {32'h0, a + b};
            4:  return {32'h0, a - b};
            5:  return {32'h0, a & b};
            6:  return {32'h0, a | b};
            7:  begin for (int i = 0; i < n; i++) r = {r[0], r[31:1]};  return {32'h0, r}; end
            8:  begin for (int i = 0; i < n; i++) r = {r[30:0], r[31]}; return {32'h0, r}; end
            9:  begin for (int i = 0; i < n; i++) r = {1'b0, r[31:1]};  return {32'h0, r}; end
            10: begin for (int i = 0; i < n; i++) r = {r[31], r[31:1]}; return {32'h0, r}; end
            11: begin for (int i = 0; i < n; i++) r = {r[30:0], 1'b0};  return {32'h0, r}; end
            15: return 64'(sa * sb);
            16: begin
                if (b == 32'h0) return 64'h0;
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            17: return {32'h0, 32'h0 - b};
            18: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    // Expected bus value: first asserted source in priority order R2..R7, PC, MDR, MAR, IR, Y, ZHi, ZLo.
    function automatic logic [31:0] model_bus(input logic [16:0] mk);
        for (int c = 2; c <= 14; c++) begin
            if (mk[c]) return m[c];
        end
        return 32'h0;
    endfunction

    task automatic zero_ctrl();
        PCout = 0; MDRout = 0; MARout = 0; IRout = 0; RYout = 0; RZoutLo = 0; RZoutHi = 0;
        R2out = 0; R3out = 0; R4out = 0; R5out = 0; R6out = 0; R7out = 0;
        PCin = 0; MDRin = 0; MARin = 0; IRin = 0; RYin = 0; RZinLo = 0; RZinHi = 0;
        LOin = 0; HIin = 0;
        R2in = 0; R3in = 0; R4in = 0; R5in = 0; R6in = 0; R7in = 0;
        IncPC = 0; MDRread = 0;
    endtask

    task automatic set_out(input int c, input logic v);
        case (c)
            2: R2out = v;  3: R3out = v;  4: R4out = v;  5: R5out = v;
            6: R6out = v;  7: R7out = v;  8: PCout = v;  9: MDRout = v;
            10: MARout = v; 11: IRout = v; 12: RYout = v; 13: RZoutHi = v;
            14: RZoutLo = v;
            default: ;
        endcase
    endtask

    task automatic set_in(input int c, input logic v);
        case (c)
            2: R2in = v;  3: R3in = v;  4: R4in = v;  5: R5in = v;
            6: R6in = v;  7: R7in = v;  8: PCin = v;  9: MDRin = v;
            10: MARin = v; 11: IRin = v; 12: RYin = v; 13: RZinHi = v;
            14: RZinLo = v; 15: LOin = v; 16: HIin = v;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        @(posedge clock);
        zero_ctrl();
        Mdatain = v; MDRread = 1; MDRin = 1;
        tick();
        zero_ctrl();
        m[C_MDR] = v;
    endtask

    task automatic xfer(input int src, input int dst);
        @(posedge clock);
        zero_ctrl();
        set_out(src, 1'b1);
        set_in(dst, 1'b1);
        tick();
        zero_ctrl();
        m[dst] = m[src];
    endtask

    task automatic read_reg(input int c, output logic [31:0] v);
        zero_ctrl();
        set_out(c, 1'b1);
        #1;
        v = BusMuxOut;
        zero_ctrl();
    endtask

    task automatic alu_run(input int op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] zlo, output logic [31:0] zhi);
        logic [63:0] e;
        load_mdr({op[4:0], 27'h0});
        xfer(C_MDR, C_IR);
        load_mdr(a);
        xfer(C_MDR, C_Y);
        load_mdr(b);
        xfer(C_MDR, C_R5);
        @(posedge clock);
        zero_ctrl();
        R5out = 1; RZinLo = 1; RZinHi = 1;
        tick();
        zero_ctrl();
        e = ref_alu(op, a, b);
        m[C_ZLO] = e[31:0];
        m[C_ZHI] = e[63:32];
        read_reg(C_ZLO, zlo);
        read_reg(C_ZHI, zhi);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        zero_ctrl();
        clear = 0; Mdatain = 0;
        #1 clear = 1;
        #1;
        n_cmp++;
        if (BusMuxOut !== 32'h0) begin
            n_err++; $display("FAIL reset_idle_bus got=%h exp=%h", BusMuxOut, 32'h0);
        end
        #1 clear = 0;
        for (int c = 0; c <= 16; c++) m[c] = 32'h0;
        for (int c = 2; c <= 14; c++) begin
            read_reg(c, v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_err++; $display("FAIL reset_reg%0d got=%h exp=%h", c, v, 32'h0);
            end
        end
    endtask

    task automatic test_register_load();
        logic [31:0] v;
        logic [31:0] vals [3];
        int          dsts [3];
        vals = '{32'hFF211111, 32'h00000004, 32'h00000028};
        dsts = '{C_R3, C_R7, C_R4};
        for (int i = 0; i < 3; i++) begin
            load_mdr(vals[i]);
            xfer(C_MDR, dsts[i]);
        end
        for (int i = 0; i < 3; i++) begin
            read_reg(dsts[i], v);
            n_cmp++;
            if (v !== vals[i]) begin
                n_err++; $display("FAIL load_reg%0d got=%h exp=%h", dsts[i], v, vals[i]);
            end
        end
    endtask

    task automatic test_mdr_bus_source();
        logic [31:0] v;
        @(posedge clock);
        zero_ctrl();
        Mdatain = 32'hDEADBEEF; MDRread = 0; R3out = 1; MDRin = 1;
        tick();
        zero_ctrl();
        read_reg(C_MDR, v);
        n_cmp++;
        if (v !== 32'hFF211111) begin
            n_err++; $display("FAIL mdr_from_bus got=%h exp=%h", v, 32'hFF211111);
        end
        m[C_MDR] = 32'hFF211111;
    endtask

    task automatic test_pc_increment();
        logic [31:0] v;
        @(posedge clock);
        zero_ctrl();
        PCout = 1; MARin = 1; IncPC = 1; RZinLo = 1;
        tick();
        zero_ctrl();
        read_reg(C_MAR, v);
        n_cmp++;
        if (v !== 32'h0) begin n_err++; $display("FAIL incpc_mar got=%h exp=%h", v, 32'h0); end
        read_reg(C_ZLO, v);
        n_cmp++;
        if (v !== 32'h1) begin n_err++; $display("FAIL incpc_zlo got=%h exp=%h", v, 32'h1); end
        read_reg(C_PC, v);
        n_cmp++;
        if (v !== 32'h0) begin n_err++; $display("FAIL incpc_pc_held got=%h exp=%h", v, 32'h0); end

        load_mdr(32'hFFFFFFFF);
        xfer(C_MDR, C_PC);
        @(posedge clock);
        zero_ctrl();
        PCout = 1; IncPC = 1; RZinLo = 1; RZinHi = 1;
        tick();
        zero_ctrl();
        read_reg(C_ZLO, v);
        n_cmp++;
        if (v !== 32'h0) begin n_err++; $display("FAIL incpc_wrap got=%h exp=%h", v, 32'h0); end

        load_mdr(32'h00000123);
        xfer(C_MDR, C_PC);
        @(posedge clock);
        zero_ctrl();
        PCout = 1; IncPC = 1; RZinLo = 1;
        tick();
        zero_ctrl();
        xfer(C_ZLO, C_PC);
        read_reg(C_PC, v);
        n_cmp++;
        if (v !== 32'h124) begin n_err++; $display("FAIL pc_via_z got=%h exp=%h", v, 32'h124); end
        m[C_MAR] = 32'h0; m[C_ZLO] = 32'h124; m[C_ZHI] = 32'h0; m[C_PC] = 32'h124;
    endtask

    task automatic test_ror_sequence();
        logic [31:0] v;
        load_mdr(32'h3A2B8000);
        xfer(C_MDR, C_IR);
        xfer(C_R3, C_Y);
        read_reg(C_Y, v);
        n_cmp++;
        if (v !== 32'hFF211111) begin n_err++; $display("FAIL ror_y got=%h exp=%h", v, 32'hFF211111); end
        @(posedge clock);
        zero_ctrl();
        R7out = 1; RZinLo = 1;
        tick();
        zero_ctrl();
        read_reg(C_ZLO, v);
        n_cmp++;
        if (v !== 32'h1FF21111) begin n_err++; $display("FAIL ror_zlo got=%h exp=%h", v, 32'h1FF21111); end
        m[C_ZLO] = 32'h1FF21111;
        xfer(C_ZLO, C_R4);
        read_reg(C_R4, v);
        n_cmp++;
        if (v !== 32'h1FF21111) begin n_err++; $display("FAIL ror_r4 got=%h exp=%h", v, 32'h1FF21111); end
    endtask

    task automatic test_muldiv();
        logic [31:0] lo, hi;
        alu_run(15, 32'hFFFFFFFE, 32'h3, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
            n_err++; $display("FAIL mul got=%h exp=%h", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        end
        alu_run(16, 32'h7, 32'h2, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'h00000001_00000003) begin
            n_err++; $display("FAIL div got=%h exp=%h", {hi, lo}, 64'h00000001_00000003);
        end
        alu_run(16, 32'hFFFFFFF9, 32'h2, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_err++; $display("FAIL div_neg got=%h exp=%h", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        end
        alu_run(16, 32'h7, 32'h0, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'h0) begin
            n_err++; $display("FAIL div_by_zero got=%h exp=%h", {hi, lo}, 64'h0);
        end
    endtask

    task automatic test_edges();
        logic [31:0] lo, hi;
        alu_run(7, 32'h12345678, 32'd0, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'h12345678) begin n_err++; $display("FAIL ror_count0 got=%h exp=%h", {hi, lo}, 64'h12345678); end
        alu_run(4, 32'h1, 32'h2, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL sub_hi_zero got=%h exp=%h", {hi, lo}, 64'hFFFFFFFF); end
        alu_run(7, 32'h12345678, 32'd32, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'h12345678) begin n_err++; $display("FAIL ror_count32 got=%h exp=%h", {hi, lo}, 64'h12345678); end
        alu_run(10, 32'h80000000, 32'd4, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'hF8000000) begin n_err++; $display("FAIL shra got=%h exp=%h", {hi, lo}, 64'hF8000000); end
        alu_run(0, 32'h5, 32'h6, lo, hi);
        n_cmp++;
        if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL bad_opcode got=%h exp=%h", {hi, lo}, 64'h0); end
        @(posedge clock);
        zero_ctrl();
        #1;
        n_cmp++;
        if (BusMuxOut !== 32'h0) begin n_err++; $display("FAIL idle_bus got=%h exp=%h", BusMuxOut, 32'h0); end
    endtask

    task automatic test_priority();
        logic [16:0] mk;
        logic [31:0] exp;
        logic [63:0] e;
        int          srcs [9];
        srcs = '{2, 3, 4, 5, 6, 7, C_PC, C_MAR, C_Y};
        for (int i = 0; i < 9; i++) begin
            load_mdr($urandom);
            xfer(C_MDR, srcs[i]);
        end
        load_mdr(32'h78000000);
        xfer(C_MDR, C_IR);
        @(posedge clock);
        zero_ctrl();
        R2out = 1; RZinLo = 1; RZinHi = 1;
        tick();
        zero_ctrl();
        e = ref_alu(15, m[C_Y], m[C_R2]);
        m[C_ZLO] = e[31:0];
        m[C_ZHI] = e[63:32];
        load_mdr($urandom);
        for (int t = 0; t < 40; t++) begin
            mk = '0;
            if (t < 13) mk[t + 2] = 1'b1;
            else for (int c = 2; c <= 14; c++) mk[c] = ($urandom_range(0, 3) == 0);
            @(posedge clock);
            zero_ctrl();
            for (int c = 2; c <= 14; c++) if (mk[c]) set_out(c, 1'b1);
            #1;
            exp = model_bus(mk);
            n_cmp++;
            if (BusMuxOut !== exp) begin
                n_err++; $display("FAIL priority mask=%h got=%h exp=%h", mk, BusMuxOut, exp);
            end
            zero_ctrl();
        end
    endtask

    task automatic test_random_alu();
        int          ops [13];
        int          op;
        logic [31:0] a, b, lo, hi, v;
        logic [63:0] e;
        ops = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : ops[$urandom_range(0, 12)];
            a  = $urandom;
            case ($urandom_range(0, 2))
                0: b = $urandom_range(0, 40);
                1: b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                default: b = $urandom;
            endcase
            alu_run(op, a, b, lo, hi);
            e = ref_alu(op, a, b);
            n_cmp++;
            if ({hi, lo} !== e) begin
                n_err++; $display("FAIL alu op=%0d a=%h b=%h got=%h exp=%h", op, a, b, {hi, lo}, e);
            end
            @(posedge clock);
            zero_ctrl();
            R5out = 1; IncPC = 1; RZinLo = 1; RZinHi = 1;
            tick();
            zero_ctrl();
            read_reg(C_ZLO, lo);
            read_reg(C_ZHI, hi);
            n_cmp++;
            if ({hi, lo} !== {32'h0, b + 32'h1}) begin
                n_err++; $display("FAIL incpc_override op=%0d got=%h exp=%h", op, {hi, lo}, {32'h0, b + 32'h1});
            end
            read_reg(C_PC, v);
            n_cmp++;
            if (v !== m[C_PC]) begin
                n_err++; $display("FAIL pc_hold got=%h exp=%h", v, m[C_PC]);
            end
        end
    endtask

    task automatic test_clear_mid();
        logic [31:0] v;
        load_mdr($urandom | 32'h1);
        xfer(C_MDR, C_R3);
        @(posedge clock);
        zero_ctrl();
        R3out = 1;
        #1;
        n_cmp++;
        if (BusMuxOut !== m[C_R3]) begin n_err++; $display("FAIL clear_pre got=%h exp=%h", BusMuxOut, m[C_R3]); end
        clear = 1;
        #1;
        n_cmp++;
        if (BusMuxOut !== 32'h0) begin n_err++; $display("FAIL clear_async got=%h exp=%h", BusMuxOut, 32'h0); end
        R3out = 0;
        #1 clear = 0;
        for (int c = 0; c <= 16; c++) m[c] = 32'h0;
        for (int c = 2; c <= 14; c++) begin
            read_reg(c, v);
            n_cmp++;
            if (v !== 32'h0) begin n_err++; $display("FAIL clear_reg%0d got=%h exp=%h", c, v, 32'h0); end
        end
        @(posedge clock);
        zero_ctrl();
        Mdatain = 32'h12345678; MDRread = 1; MDRin = 1;
        clear = 1;
        tick();
        clear = 0;
        zero_ctrl();
        read_reg(C_MDR, v);
        n_cmp++;
        if (v !== 32'h0) begin n_err++; $display("FAIL clear_over_load got=%h exp=%h", v, 32'h0); end
        load_mdr(32'h5);
        read_reg(C_MDR, v);
        n_cmp++;
        if (v !== 32'h5) begin n_err++; $display("FAIL load_after_clear got=%h exp=%h", v, 32'h5); end
    endtask

    initial begin
        test_reset();
        test_register_load();
        test_mdr_bus_source();
        test_pc_increment();
        test_ror_sequence();
        test_muldiv();
        test_edges();
        test_priority();
        test_random_alu();
        test_clear_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have one clock, `clock`, input, 1 bit; all register loads occur on its falling edge.
REQ-002 SHALL have reset `clear`, input, 1 bit, asynchronous, active-high; it clears every register.
REQ-003 SHALL have `Mdatain`, input, 32 bits: memory read data.
REQ-004 SHALL have `MDRread`, input, 1 bit: selects the MDR load source, 1 = Mdatain, 0 = bus.
REQ-005 SHALL have bus-drive inputs, 1 bit each: `PCout`, `MDRout`, `MARout`, `IRout`, `RYout`, `RZoutLo`, `RZoutHi`, `R2out`..`R7out`.
REQ-006 SHALL have load-enable inputs, 1 bit each: `PCin`, `MDRin`, `MARin`, `IRin`, `RYin`, `RZinLo`, `RZinHi`, `LOin`, `HIin`, `R2in`..`R7in`.
REQ-007 SHALL have `IncPC`, input, 1 bit: forces the ALU to compute bus+1.
REQ-008 SHALL have `BusMuxOut`, output, 32 bits: the current internal bus value, for observation.

Function
REQ-009 SHALL contain 32-bit registers PC, MDR, MAR, IR, Y, LO, HI and R2..R7, plus a 64-bit Z split into ZLo and ZHi.
REQ-010 Bus SHALL be a combinational mux of the single asserted *out source.
REQ-011 Bus SHALL be 0 when no *out source is asserted.
REQ-012 When several *out sources are asserted, priority SHALL be: R2..R7 (ascending), PC, MDR, MAR, IR, Y, ZHi, ZLo.
REQ-013 Each enabled register SHALL load from the bus on the falling clock edge, with these exceptions: MDR (REQ-014) and ZLo/ZHi (REQ-015).
REQ-014 MDR SHALL load `MDRread ? Mdatain : bus` when MDRin=1.
REQ-015 ZLo SHALL load ALU[31:0] when RZinLo=1; ZHi SHALL load ALU[63:32] when RZinHi=1.
REQ-016 ALU operands SHALL be A = Y and B = bus.
REQ-017 The ALU operation SHALL be selected by IR[31:27].
REQ-018 ALU opcodes SHALL be:
  - 00011 add; 00100 sub (A−B)
  - 00101 and; 00110 or
  - 00111 ror; 01000 rol
  - 01001 shr (logical); 01010 shra (arithmetic); 01011 shl
  - 01111 mul (signed, full 64-bit)
  - 10000 div (signed: quotient in [31:0], remainder in [63:32])
  - 10001 neg (−B); 10010 not (~B)
  - any other opcode: result 0
REQ-019 Shift and rotate counts SHALL use B[4:0]; a count of 0 leaves A unchanged.
REQ-020 Division by zero SHALL produce a result of 0.
REQ-021 For all non-mul/div results, ALU[63:32] SHALL be 0.
REQ-022 IncPC=1 SHALL override the opcode, giving ALU = {32'b0, bus+1} with wrap-around (FFFFFFFF+1 = 0).
REQ-023 IncPC SHALL NOT write PC directly; PC changes only via PCin.
REQ-024 A register not enabled SHALL hold its value.
REQ-025 LO and HI SHALL be load-only (no bus drive).
REQ-026 MAR SHALL be readable on the bus via MARout.
REQ-027 There SHALL be no combinational path from a *in signal to the bus.

Reset
REQ-028 clear=1 SHALL immediately zero PC, MDR, MAR, IR, Y, Z, LO, HI and R2..R7.
REQ-029 clear=1 SHALL override any load occurring on the same edge.
REQ-030 After clear=1, BusMuxOut SHALL be 0 while no *out source is asserted.

Verification
REQ-031 Assert clear mid-operation (after R3 has been loaded) -> all registers read 0 immediately, without waiting for a clock edge.
REQ-032 Register load: Mdatain=FF211111 with MDRread=MDRin=1 for one cycle, then MDRout=R3in=1 -> R3=FF211111; repeat for R7=00000004 and R4=00000028.
REQ-033 PC increment: with PC=0, assert PCout, MARin, IncPC, RZinLo together -> MAR=0, ZLo=1, PC still 0.
REQ-034 ROR sequence:
  - MDR ← 3A2B8000, then IR ← MDR
  - R3out+RYin -> Y = FF211111
  - R7out+RZinLo -> ZLo = 1FF21111
  - RZoutLo+R4in -> R4 = 1FF21111
REQ-035 mul/div with Y=FFFFFFFE, bus=00000003:
  - mul -> Z = FFFFFFFF_FFFFFFFA
  - div with Y=7, bus=2 -> ZLo=3, ZHi=1
  - div by 0 -> Z=0
REQ-036 Edge cases:
  - ror count 0 and count 32 -> value unchanged
  - shra of 80000000 by 4 -> F8000000
  - no *out asserted -> BusMuxOut = 0
